// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame transmitter.
//   tx_state_t : frame FSM states (IDLE -> START -> DATA -> STOP -> IDLE)
//   LINE_IDLE / START_LVL / STOP_LVL : line levels for idle, start and stop bits
//   cnt_width  : counter width able to hold 0..n-1, never narrower than 1 bit
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the terminal
// count, marking the last cycle of the current bit.
//   clk     : clock, posedge
//   reset   : synchronous active-high reset, clears the count
//   clear_i : restart the count at 0 (asserted on frame accept)
//   tick_o  : high during the terminal-count cycle
module bit_timer
  import serial_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int TW = cnt_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] TERM = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Free-runs outside a frame; the FSM ignores ticks in IDLE and the accept
  // clear lines the count up with the start bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == TERM)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == TERM);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter. A DATA_W word accepted on the
// valid/ready handshake goes out on tx_o as start bit (0), DATA_W data bits,
// stop bit (1), each bit held CLKS_PER_BIT cycles.
//
// Handshake: a word is accepted at a posedge where valid_i && ready_o; data_i
// is sampled only then. ready_o is high exactly while the FSM is IDLE, which
// includes the done_o cycle, so a held valid_i chains frames with a single
// idle-high cycle between stop and the next start bit.
//
//   clk     : clock, posedge
//   reset   : synchronous active-high reset
//   data_i  : word to send
//   valid_i : producer has a word
//   ready_o : block can accept (state IDLE)
//   tx_o    : registered serial line, idles high
//   busy_o  : frame on the line (state START..STOP)
//   done_o  : one-cycle pulse after the stop bit completes
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit LSB_FIRST    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int BW = cnt_width(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic              accept;
  logic              tick;
  logic              next_bit;
  logic [DATA_W-1:0] shift_nxt;

  assign accept = valid_i && (state_q == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (accept),
    .tick_o  (tick)
  );

  // The bit leaving the shift register next, and the register after it leaves.
  always_comb begin
    if (LSB_FIRST) begin
      next_bit  = shift_q[0];
      shift_nxt = shift_q >> 1;
    end else begin
      next_bit  = shift_q[DATA_W-1];
      shift_nxt = shift_q << 1;
    end
  end

  // tx_d is the level for the bit that starts after this edge, so tx_o
  // changes on the same edge as the state it belongs to.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = LINE_IDLE;
        if (valid_i) begin
          state_d   = START;
          shift_d   = data_i;
          bit_cnt_d = '0;
          tx_d      = START_LVL;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          tx_d      = next_bit;
          shift_d   = shift_nxt;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        // bit_cnt_q indexes the data bit currently on the line.
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = STOP_LVL;
          end else begin
            tx_d      = next_bit;
            shift_d   = shift_nxt;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          tx_d    = LINE_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= LINE_IDLE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q != IDLE);
  assign tx_o    = tx_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx. Two instances: dut_a (8 bits, 4 clk per
// bit, LSB first) and dut_b (8 bits, 1 clk per bit, MSB first). Expected frames
// are hand-written 10-bit patterns, first bit on the line at the left.
module tb_serial_frame_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, tx_a, busy_a, done_a;
  logic       ready_b, tx_b, busy_b, done_b;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .data_i(data_a), .valid_i(valid_a),
    .ready_o(ready_a), .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a)
  );

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .data_i(data_b), .valid_i(valid_b),
    .ready_o(ready_b), .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input bit sel, input string tag);
    check_eq({tag, "_tx"},    sel ? tx_b    : tx_a,    1);
    check_eq({tag, "_ready"}, sel ? ready_b : ready_a, 1);
    check_eq({tag, "_busy"},  sel ? busy_b  : busy_a,  0);
    check_eq({tag, "_done"},  sel ? done_b  : done_a,  0);
  endtask

  // ---------------- driver ----------------
  // Caller has valid/data set up; the next posedge is the accept edge.
  // Returns at the done-cycle sample. hold keeps valid high for chaining;
  // scramble randomises data/valid while the frame is on the line.
  task automatic run_frame(input bit sel, input logic [9:0] pat,
                           input bit hold, input bit scramble);
    int cpb;
    logic [0:0] e;
    cpb = sel ? 1 : 4;
    for (int b = 0; b < 10; b++) exp_q.push_back(pat[9-b]);
    @(posedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        check_eq("tx_bit", sel ? tx_b : tx_a, {31'd0, e});
        check_eq("busy",   sel ? busy_b  : busy_a,  1);
        check_eq("ready",  sel ? ready_b : ready_a, 0);
        check_eq("done",   sel ? done_b  : done_a,  0);
        if (scramble) begin
          data_a  = 8'($urandom);
          valid_a = 1'($urandom_range(0, 1));
        end
      end
    end
    @(negedge clk);
    check_eq("done_pulse", sel ? done_b  : done_a,  1);
    check_eq("done_tx",    sel ? tx_b    : tx_a,    1);
    check_eq("done_ready", sel ? ready_b : ready_a, 1);
    check_eq("done_busy",  sel ? busy_b  : busy_a,  0);
    if (!hold) begin
      if (sel) valid_b = 1'b0;
      else     valid_a = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] pat_a5;
    pat_a5  = 10'b0101001011;
    reset   = 1'b1;
    valid_a = 1'b1;
    data_a  = 8'hA5;
    valid_b = 1'b1;
    data_b  = 8'h81;

    // Reset held 3 cycles with valid high: nothing accepted.
    repeat (3) begin
      @(negedge clk);
      check_idle(1'b0, "rst_a");
      check_idle(1'b1, "rst_b");
    end
    reset   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    @(negedge clk);
    check_idle(1'b0, "post_rst_a");

    // Single frame 8'hA5.
    data_a  = 8'hA5;
    valid_a = 1'b1;
    run_frame(1'b0, pat_a5, 1'b0, 1'b0);
    @(negedge clk);
    check_idle(1'b0, "after_a5");

    // Back-to-back 8'h00 then 8'hFF.
    data_a  = 8'h00;
    valid_a = 1'b1;
    run_frame(1'b0, 10'b0000000001, 1'b1, 1'b0);
    data_a  = 8'hFF;
    run_frame(1'b0, 10'b0111111111, 1'b0, 1'b0);
    @(negedge clk);
    check_idle(1'b0, "after_ff");

    // Input churn during a frame of 8'h5A.
    data_a  = 8'h5A;
    valid_a = 1'b1;
    run_frame(1'b0, 10'b0010110101, 1'b0, 1'b1);
    @(negedge clk);
    check_idle(1'b0, "after_5a");

    // Reset mid-frame at N+12.
    data_a  = 8'hA5;
    valid_a = 1'b1;
    @(posedge clk);
    #1 valid_a = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check_eq("mid_tx", tx_a, {31'd0, pat_a5[9 - (i - 1) / 4]});
    end
    reset = 1'b1;
    @(negedge clk);
    check_idle(1'b0, "mid_rst");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle(1'b0, "mid_rst_idle");
    end
    data_a  = 8'h3C;
    valid_a = 1'b1;
    run_frame(1'b0, 10'b0001111001, 1'b0, 1'b0);

    // One clock per bit, MSB first, 8'h81.
    data_b  = 8'h81;
    valid_b = 1'b1;
    run_frame(1'b1, 10'b0100000011, 1'b0, 1'b0);
    @(negedge clk);
    check_idle(1'b1, "after_81");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
